booth_r4_mult: RTL



---
 rtl/booth_r4_pkg.sv | 26 ++
 rtl/booth_r4_mult_if.sv | 31 +++
 rtl/booth_r4_enc.sv | 21 ++
 rtl/booth_r4_mult.sv | 105 ++++++++++
 4 files changed

// File: rtl/booth_r4_pkg.sv
// Shared types and recoding constants for the radix-4 Booth multiplier.
package booth_r4_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // One recoded Booth digit: value = zero ? 0 : (neg ? -1 : +1) * (two ? 2 : 1)
  typedef struct packed {
    logic zero;
    logic neg;
    logic two;
  } digit_t;

  localparam logic [2:0] REC_Z0  = 3'b000;
  localparam logic [2:0] REC_P1A = 3'b001;
  localparam logic [2:0] REC_P1B = 3'b010;
  localparam logic [2:0] REC_P2  = 3'b011;
  localparam logic [2:0] REC_M2  = 3'b100;
  localparam logic [2:0] REC_M1A = 3'b101;
  localparam logic [2:0] REC_M1B = 3'b110;
  localparam logic [2:0] REC_Z1  = 3'b111;

endpackage

// File: rtl/booth_r4_mult_if.sv
// Start/ready handshake and operand/product bus of booth_r4_mult.
// The sgn signal exists only when BOOTH_UNSIGNED_EN is defined.
interface booth_r4_mult_if #(parameter int WIDTH = 8);

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
`ifdef BOOTH_UNSIGNED_EN
  logic               sgn;
`endif
  logic               busy;
  logic [2*WIDTH-1:0] p;
  logic               rdy;

  modport master (
`ifdef BOOTH_UNSIGNED_EN
    output sgn,
`endif
    output start, a, b,
    input  busy, p, rdy
  );

  modport slave (
`ifdef BOOTH_UNSIGNED_EN
    input  sgn,
`endif
    input  start, a, b,
    output busy, p, rdy
  );

endinterface

// File: rtl/booth_r4_enc.sv
// Combinational radix-4 Booth recoder: 3 multiplier bits -> {zero, neg, two}.
module booth_r4_enc
  import booth_r4_pkg::*;
(
  input  logic [2:0] bits,
  output digit_t     digit
);

  always_comb begin
    // NOTE: default every output first so no path through the case leaves it unassigned (no latch).
    digit = '{zero: 1'b1, neg: 1'b0, two: 1'b0};
    case (bits)
      REC_P1A, REC_P1B: digit = '{zero: 1'b0, neg: 1'b0, two: 1'b0};
      REC_P2:           digit = '{zero: 1'b0, neg: 1'b0, two: 1'b1};
      REC_M2:           digit = '{zero: 1'b0, neg: 1'b1, two: 1'b1};
      REC_M1A, REC_M1B: digit = '{zero: 1'b0, neg: 1'b1, two: 1'b0};
      default:          digit = '{zero: 1'b1, neg: 1'b0, two: 1'b0};
    endcase
  end

endmodule

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per cycle.
// Define BOOTH_UNSIGNED_EN to add the sgn input and unsigned operation.
module booth_r4_mult
  import booth_r4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  booth_r4_mult_if.slave  bus
);

  localparam int EXT_W = WIDTH + 2;
  localparam int ACC_W = 2 * WIDTH + 4;
  localparam int CNT_W = $clog2(WIDTH / 2 + 2);

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_last;
  logic [ACC_W-1:0]     acc, a_sh, mag, pp;
  logic [EXT_W:0]       b_sh;
  logic [EXT_W-1:0]     a_ext, b_ext;
  logic                 signed_op;
  logic [3:0]           acc_unused;
  logic [2*WIDTH-1:0]   acc_prod;
  digit_t               digit;

`ifdef BOOTH_UNSIGNED_EN
  logic sgn_q;
  assign signed_op = bus.sgn;
  // Unsigned needs one more digit to consume the zero-extended top bits.
  assign cnt_last  = sgn_q ? CNT_W'(WIDTH / 2 - 1) : CNT_W'(WIDTH / 2);
`else
  assign signed_op = 1'b1;
  assign cnt_last  = CNT_W'(WIDTH / 2 - 1);
`endif

  assign a_ext = {{2{signed_op & bus.a[WIDTH-1]}}, bus.a};
  assign b_ext = {{2{signed_op & bus.b[WIDTH-1]}}, bus.b};
  assign {acc_unused, acc_prod} = acc;
  assign bus.busy = (state != IDLE);

  // Multiplier shifts right and multiplicand left, so digit i always sits at b_sh[2:0].
  booth_r4_enc u_enc (
    .bits  (b_sh[2:0]),
    .digit (digit)
  );

  assign mag = digit.two ? {a_sh[ACC_W-2:0], 1'b0} : a_sh;
  assign pp  = digit.zero ? '0 : (digit.neg ? -mag : mag);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (cnt == cnt_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      bus.p   <= '0;
      bus.rdy <= 1'b0;
`ifdef BOOTH_UNSIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      bus.rdy <= 1'b0;
      unique case (state)
        IDLE: if (bus.start) begin
          a_sh <= {{(ACC_W - EXT_W){a_ext[EXT_W-1]}}, a_ext};
          b_sh <= {b_ext, 1'b0};
          acc  <= '0;
          cnt  <= '0;
`ifdef BOOTH_UNSIGNED_EN
          sgn_q <= bus.sgn;
`endif
        end
        CALC: begin
          acc  <= acc + pp;
          a_sh <= a_sh << 2;
          b_sh <= b_sh >> 2;
          cnt  <= cnt + CNT_W'(1);
        end
        DONE: begin
          bus.p   <= acc_prod;
          bus.rdy <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
